mii_rx_nibble_aligner: RTL and testbench

- Receive-side front end for the Ethernet MAC, running in the MII receive clock domain.
- Sits between the MII pads (rxd/rx_dv/rx_er) and the MAC's byte-wide GMII receive port.
- Strips preamble and SFD, packs nibbles into bytes (low nibble first), and marks frame boundaries and errors.
- Replaces the zero-padded nibble feed into the MAC RX data bus.

---
 rtl/mii_rx_nibble_aligner.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_mii_rx_nibble_aligner.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_nibble_aligner.sv
// -----------------------------------------------------------------------------
// mii_rx_nibble_aligner
//
// MII receive front end. Registers the MII pads once, hunts for a preamble of
// at least MIN_PRE 0x5 nibbles followed by the 0xD SFD nibble, then packs the
// nibble stream into bytes (low nibble first) for the MAC's byte-wide port.
// One assembled byte is always held back so the end-of-frame marker can ride
// on the last byte. Because of that holdback the eof strobe follows the last
// regular strobe by a single cycle.
//
// Optional feature (compile-time macro MII_RX_FCS_CHK_EN):
//   defined   - a reflected CRC-32 runs over every assembled byte, including
//               the 4 FCS bytes. A bad residue at eof raises out_fcs_err and
//               out_err.
//   undefined - no CRC logic, out_fcs_err is held at 0.
//
// Ports:
//   clock        in   MII RX clock, rising edge
//   reset        in   asynchronous, active-high reset
//   mii_rxd      in   [3:0] receive nibble
//   mii_rx_dv    in   receive data valid
//   mii_rx_er    in   receive error
//   out_data     out  [7:0] assembled byte
//   out_valid    out  one-cycle strobe, out_data valid
//   out_sof      out  with out_valid: first byte of frame
//   out_eof      out  with out_valid: last byte of frame
//   out_err      out  with out_eof: frame is bad
//   out_fcs_err  out  with out_eof: FCS mismatch
//   stat_good    out  [15:0] frames ended without error (wraps)
//   stat_bad     out  [15:0] frames ended with error plus dropped preambles (wraps)
// -----------------------------------------------------------------------------
module mii_rx_nibble_aligner #(
    parameter int MIN_PRE   = 4,
    parameter int MAX_BYTES = 1522,
    parameter int LEN_W     = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  mii_rxd,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic        out_fcs_err,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DLO,
        S_DHI,
        S_DROP
    } state_t;

    localparam int              PRE_W   = $clog2(MIN_PRE + 1);
    localparam logic [PRE_W-1:0] PRE_SAT = PRE_W'(MIN_PRE);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

    // Registered copy of the pads; everything below works on this copy.
    logic [3:0] rxd_q;
    logic       dv_q;
    logic       er_q;

    state_t state;
    state_t state_next;

    logic [PRE_W-1:0] pre_cnt;
    logic [3:0]       lo_nib;
    logic [7:0]       hold_data;
    logic             hold_full;
    logic             hold_sof;
    logic [LEN_W-1:0] byte_cnt;
    logic             err_q;

    logic [7:0] new_byte;
    logic       pre_ok;
    logic       at_limit;
    logic       fcs_bad;

    // Decisions for the current cycle, registered onto the outputs below.
    logic emit;
    logic emit_eof;
    logic end_err;
    logic load_hold;
    logic frame_start;
    logic inc_good;
    logic inc_bad;

    assign new_byte = {rxd_q, lo_nib};
    assign pre_ok   = (pre_cnt >= PRE_SAT);
    // The byte now completing would be number MAX_BYTES+1.
    assign at_limit = (byte_cnt == LEN_MAX);

    // -------------------------------------------------------------------------
    // Input stage
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxd_q <= 4'h0;
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
        end else begin
            rxd_q <= mii_rxd;
            dv_q  <= mii_rx_dv;
            er_q  <= mii_rx_er;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    // NOTE: each combinational block assigns a default to every output first,
    // so no path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (dv_q) state_next = (!er_q && rxd_q == 4'h5) ? S_PRE : S_DROP;
            end
            S_PRE: begin
                if (!dv_q)                            state_next = S_IDLE;
                else if (er_q)                        state_next = S_DROP;
                else if (rxd_q == 4'h5)               state_next = S_PRE;
                else if (rxd_q == 4'hD && pre_ok)     state_next = S_DLO;
                else                                  state_next = S_DROP;
            end
            S_DLO: begin
                state_next = dv_q ? S_DHI : S_IDLE;
            end
            S_DHI: begin
                if (!dv_q)         state_next = S_IDLE;
                else if (at_limit) state_next = S_DROP;
                else               state_next = S_DLO;
            end
            S_DROP: begin
                if (!dv_q) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decisions
    // -------------------------------------------------------------------------
    always_comb begin
        emit        = 1'b0;
        emit_eof    = 1'b0;
        end_err     = 1'b0;
        load_hold   = 1'b0;
        frame_start = 1'b0;
        inc_good    = 1'b0;
        inc_bad     = 1'b0;
        unique case (state)
            S_PRE: begin
                if (dv_q) begin
                    if (er_q)                            inc_bad     = 1'b1;
                    else if (rxd_q == 4'hD && pre_ok)    frame_start = 1'b1;
                    else if (rxd_q != 4'h5)              inc_bad     = 1'b1;
                end
            end
            S_DLO: begin
                // dv falling on an even nibble count is the clean end.
                if (!dv_q) begin
                    if (hold_full) begin
                        emit     = 1'b1;
                        emit_eof = 1'b1;
                        end_err  = err_q | fcs_bad;
                    end else begin
                        inc_bad  = 1'b1;   // zero-length frame
                    end
                end
            end
            S_DHI: begin
                if (!dv_q || at_limit) begin
                    // Odd nibble count or oversize frame: close it as bad.
                    if (hold_full) begin
                        emit     = 1'b1;
                        emit_eof = 1'b1;
                        end_err  = 1'b1;
                    end else begin
                        inc_bad  = 1'b1;
                    end
                end else begin
                    load_hold = 1'b1;
                    emit      = hold_full;
                end
            end
            default: ;
        endcase
        if (emit_eof) begin
            inc_good = ~end_err;
            inc_bad  = end_err;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath, outputs and statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt     <= '0;
            lo_nib      <= 4'h0;
            hold_data   <= 8'h00;
            hold_full   <= 1'b0;
            hold_sof    <= 1'b0;
            byte_cnt    <= '0;
            err_q       <= 1'b0;
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_err     <= 1'b0;
            out_fcs_err <= 1'b0;
            stat_good   <= 16'h0000;
            stat_bad    <= 16'h0000;
        end else begin
            out_valid   <= emit;
            out_data    <= emit ? hold_data : 8'h00;
            out_sof     <= emit & hold_sof;
            out_eof     <= emit_eof;
            out_err     <= emit_eof & end_err;
            out_fcs_err <= emit_eof & fcs_bad;

            if (inc_good) stat_good <= stat_good + 16'd1;
            if (inc_bad)  stat_bad  <= stat_bad + 16'd1;

            // The first 0x5 is consumed in IDLE, so PRE starts counting at 1.
            if (state == S_IDLE)
                pre_cnt <= PRE_W'(1);
            else if (state == S_PRE && dv_q && rxd_q == 4'h5 && pre_cnt != PRE_SAT)
                pre_cnt <= pre_cnt + PRE_W'(1);

            if (frame_start) begin
                hold_full <= 1'b0;
                byte_cnt  <= '0;
                err_q     <= 1'b0;
            end

            if ((state == S_DLO || state == S_DHI) && dv_q && er_q)
                err_q <= 1'b1;

            if (state == S_DLO && dv_q)
                lo_nib <= rxd_q;

            if (load_hold) begin
                hold_data <= new_byte;
                hold_full <= 1'b1;
                hold_sof  <= (byte_cnt == '0);
                byte_cnt  <= byte_cnt + LEN_W'(1);
            end else if (emit_eof) begin
                hold_full <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional FCS check
    // -------------------------------------------------------------------------
`ifdef MII_RX_FCS_CHK_EN
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;  // 0x04C11DB7 reflected
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    logic [31:0] crc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            r[i] = v[31-i];
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset)            crc <= 32'hFFFFFFFF;
        else if (frame_start) crc <= 32'hFFFFFFFF;
        else if (load_hold)   crc <= crc32_byte(crc, new_byte);
    end

    // The shift register holds the residue bit-reversed.
    assign fcs_bad = (bit_rev32(crc) != CRC_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

endmodule

// File: tb/tb_mii_rx_nibble_aligner.sv
// -----------------------------------------------------------------------------
// tb_mii_rx_nibble_aligner
//
// Scoreboard bench. Each frame is described at byte level; a reference model
// turns the description into the list of strobes the MAC should see and the
// statistics deltas, and pushes the strobes into a queue. A monitor process
// pops and compares on every out_valid. Build with +define+MII_RX_FCS_CHK_EN
// to exercise the FCS path.
// -----------------------------------------------------------------------------
module tb_mii_rx_nibble_aligner;

    localparam int MIN_PRE   = 4;
    localparam int MAX_BYTES = 1522;
    localparam int LEN_W     = 11;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  mii_rxd;
    logic        mii_rx_dv;
    logic        mii_rx_er;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        out_err;
    logic        out_fcs_err;
    logic [15:0] stat_good;
    logic [15:0] stat_bad;

    mii_rx_nibble_aligner #(
        .MIN_PRE   (MIN_PRE),
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mii_rxd     (mii_rxd),
        .mii_rx_dv   (mii_rx_dv),
        .mii_rx_er   (mii_rx_er),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_err     (out_err),
        .out_fcs_err (out_fcs_err),
        .stat_good   (stat_good),
        .stat_bad    (stat_bad)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
        logic       fcs;
        logic       lat;   // check eof latency against dv fall
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fr[$];       // bytes of the frame being built
    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_good = 0;
    int         exp_bad  = 0;
    int         cyc      = 0;
    int         exp_eof_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc32_std(input int count);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < count; i++) begin
            c = c ^ {24'h000000, fr[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // A frame of m bytes carries a good FCS when its last four bytes,
    // little-endian, equal the CRC-32 of everything before them.
    function automatic bit fcs_ok(input int m);
        if (m < 4) return 1'b0;
        return crc32_std(m - 4) == {fr[m-1], fr[m-2], fr[m-3], fr[m-4]};
    endfunction

    task automatic append_fcs();
        logic [31:0] c;
        c = crc32_std(fr.size());
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
        fr.push_back(c[23:16]);
        fr.push_back(c[31:24]);
    endtask

    task automatic fill_random(input int len);
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    endtask

    task automatic predict(input int npre, input bit extra, input int er_byte);
        int   n;
        int   inc;
        bit   bad;
        bit   fcs;
        exp_t e;
        n = fr.size();
        if (npre < MIN_PRE || n == 0) begin
            exp_bad++;
            return;
        end
        inc = (n > MAX_BYTES) ? MAX_BYTES : n;
        fcs = 1'b0;
`ifdef MII_RX_FCS_CHK_EN
        fcs = !fcs_ok(inc);
`endif
        bad = extra || (er_byte >= 0) || (n > MAX_BYTES) || fcs;
        for (int i = 0; i < inc; i++) begin
            e.data = fr[i];
            e.sof  = (i == 0);
            e.eof  = (i == inc - 1);
            e.err  = e.eof && bad;
            e.fcs  = e.eof && fcs;
            e.lat  = e.eof && (n <= MAX_BYTES);
            exp_q.push_back(e);
        end
        if (bad) exp_bad++;
        else     exp_good++;
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input logic dv, input logic [3:0] nib, input logic er);
        @(negedge clock);
        mii_rx_dv = dv;
        mii_rxd   = nib;
        mii_rx_er = er;
    endtask

    task automatic check_stats();
        check("stat_good", {16'h0, stat_good}, {16'h0, 16'(exp_good)});
        check("stat_bad",  {16'h0, stat_bad},  {16'h0, 16'(exp_bad)});
    endtask

    task automatic send_frame(input int npre, input bit extra, input logic [3:0] extra_nib,
                              input int er_byte, input int gap);
        logic [7:0] b;
        predict(npre, extra, er_byte);
        for (int i = 0; i < npre; i++) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < fr.size(); i++) begin
            b = fr[i];
            drive(1'b1, b[3:0], i == er_byte);
            drive(1'b1, b[7:4], i == er_byte);
        end
        if (extra) drive(1'b1, extra_nib, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        exp_eof_cyc = cyc + 2;
        for (int i = 1; i < gap; i++) drive(1'b0, 4'h0, 1'b0);
        if (gap >= 3) check_stats();
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {24'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data",    {24'h0, out_data}, {24'h0, e.data});
                    check("out_sof",     {31'h0, out_sof},     {31'h0, e.sof});
                    check("out_eof",     {31'h0, out_eof},     {31'h0, e.eof});
                    check("out_err",     {31'h0, out_err},     {31'h0, e.err});
                    check("out_fcs_err", {31'h0, out_fcs_err}, {31'h0, e.fcs});
                    if (e.lat) check("eof_latency", cyc, exp_eof_cyc);
                end
            end else if (!reset) begin
                check("idle_flags", {28'h0, out_sof, out_eof, out_err, out_fcs_err}, 32'h0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] b;
        int         len;
        int         npre;
        int         er_byte;
        bit         extra;

        reset     = 1'b1;
        mii_rxd   = 4'h0;
        mii_rx_dv = 1'b0;
        mii_rx_er = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        check("reset_data",  {24'h0, out_data},  32'h0);
        check("reset_flags", {28'h0, out_sof, out_eof, out_err, out_fcs_err}, 32'h0);
        check_stats();
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 64 incrementing bytes after a 7-nibble preamble
        fr.delete();
        for (int i = 0; i < 64; i++) fr.push_back(8'(i));
        send_frame(7, 1'b0, 4'h0, -1, 4);

        // short preamble is dropped, a following long preamble is accepted
        fill_random(6);
        send_frame(2, 1'b0, 4'h0, -1, 4);
        fill_random(16);
        send_frame(8, 1'b0, 4'h0, -1, 4);

        // odd nibble count
        fill_random(10);
        send_frame(7, 1'b1, 4'hA, -1, 4);

        // receive error on byte 5 of 20
        fill_random(20);
        send_frame(7, 1'b0, 4'h0, 5, 4);

        // oversize frame truncates at MAX_BYTES
        fill_random(1530);
        send_frame(7, 1'b0, 4'h0, -1, 4);

        // zero-length frame
        fr.delete();
        send_frame(7, 1'b0, 4'h0, -1, 4);

`ifdef MII_RX_FCS_CHK_EN
        // correct FCS, then one payload bit flipped
        fill_random(60);
        append_fcs();
        send_frame(7, 1'b0, 4'h0, -1, 4);
        fill_random(60);
        append_fcs();
        b = fr[5];
        fr[5] = b ^ 8'h10;
        send_frame(7, 1'b0, 4'h0, -1, 4);
`endif

        // reset mid-frame: bytes 0..8 are out, byte 9 is held and discarded
        fill_random(12);
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            e.data = fr[i];
            e.sof  = (i == 0);
            e.eof  = 1'b0;
            e.err  = 1'b0;
            e.fcs  = 1'b0;
            e.lat  = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 7; i++) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            b = fr[i];
            drive(1'b1, b[3:0], 1'b0);
            drive(1'b1, b[7:4], 1'b0);
        end
        b = fr[10];
        drive(1'b1, b[3:0], 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_valid", {31'h0, out_valid}, 32'h0);
        check("midreset_eof",   {31'h0, out_eof},   32'h0);
        exp_good = 0;
        exp_bad  = 0;
        check_stats();
        mii_rx_dv = 1'b0;
        mii_rxd   = 4'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("midreset_drained", exp_q.size(), 32'h0);

        // recovery after reset
        fill_random(12);
        send_frame(MIN_PRE, 1'b0, 4'h0, -1, 4);

        // randomized frames, including back-to-back with a one-cycle gap
        for (int f = 0; f < 40; f++) begin
            npre  = int'($urandom_range(1, 10));
            len   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(4, 80));
            extra = ($urandom_range(0, 5) == 0);
            fill_random(len);
`ifdef MII_RX_FCS_CHK_EN
            if (len > 0 && $urandom_range(0, 1) == 1) append_fcs();
`endif
            er_byte = (fr.size() > 0 && $urandom_range(0, 7) == 0)
                      ? int'($urandom_range(0, fr.size() - 1)) : -1;
            send_frame(npre, extra, 4'($urandom), er_byte, int'($urandom_range(1, 4)));
        end

        repeat (10) @(negedge clock);
        check_stats();
        check("queue_empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
